ofm_readout: RTL

- Drains a finished OFM region from the OFM dual-port RAM after `done_CNN` and streams it out as `DATA_WIDTH` words.
- Sits directly downstream of `yolov3_tiny`. It replaces the bench's hierarchical peek into `ofm_dpram.mem` with a synthesizable valid/ready stream for host readout and golden comparison.
- Example region: base address 13520, 3x3x16 = 144 words.

---
 rtl/cnn_pkg.sv | 7 +
 rtl/ofm_readout_if.sv | 9 +
 rtl/sync_fifo_fwft.sv | 39 +++
 rtl/ofm_readout.sv | 78 +++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared OFM geometry constants and the readout FSM state type
package cnn_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int OFM_RAM_SIZE = 2378675;
  localparam int ADDR_W = $clog2(OFM_RAM_SIZE);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} readout_state_t;
endpackage

// File: rtl/ofm_readout_if.sv
// ofm_readout_if: valid/ready word stream (valid, data, last from master; ready from slave)
interface ofm_readout_if #(parameter int DW = 64);
  logic valid;
  logic last;
  logic ready;
  logic [DW-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; ports push/pop/din in, dout/empty/full/count out
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a push into a full FIFO is still honoured when a pop frees a slot in the same cycle
  assign do_push = push && (!full || do_pop);
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign dout = mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/ofm_readout.sv
// ofm_readout: drains num_words OFM RAM words from base_addr (on start) into stream m; ram_* = RAM port A, busy/done = status
module ofm_readout
  import cnn_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_words,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  ofm_readout_if.master         m,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  readout_state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0] num_q, issued, accepted;
  logic inflight, pop, empty, full, credit_ok, last_head;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] dout;
  sync_fifo_fwft #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(inflight), .pop(pop), .din(ram_rd_data),
    .dout(dout), .empty(empty), .full(full), .count(count)
  );
  // reads already in flight count against FIFO space so the FIFO can never overflow
  assign credit_ok = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign pop = !empty && m.ready;
  assign last_head = accepted == num_q - CNT_W'(1);
  assign m.valid = !empty;
  assign m.data = dout;
  assign m.last = !empty && last_head;
  assign ram_addr = addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (num_words == '0) ? FIN : READ;
      READ: if (ram_rd_en && issued == num_q - CNT_W'(1)) state_nx = DRAIN;
      DRAIN: if (pop && last_head) state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    ram_rd_en = state == READ && credit_ok;
    busy = state == READ || state == DRAIN;
    done = state == FIN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q <= '0;
      num_q <= '0;
      issued <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= ram_rd_en;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        num_q <= num_words;
        issued <= '0;
        accepted <= '0;
      end else begin
        if (ram_rd_en) begin
          addr_q <= (addr_q == ADDR_W'(OFM_RAM_SIZE - 1)) ? '0 : addr_q + ADDR_W'(1);
          issued <= issued + CNT_W'(1);
        end
        if (pop) accepted <= accepted + CNT_W'(1);
      end
    end
endmodule
